// File: rtl/apb_master_bridge.sv
// Single-outstanding APB4 requester: takes one valid/ready command, runs the
// APB SETUP/ACCESS transfer and holds the result on a valid/ready response.
module apb_master_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  input  logic [2:0]              cmd_prot,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [2:0]              pprot,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic                    pready,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pslverr,
  output logic [1:0]              state_dbg
);

  // Handshakes: a transfer happens on a rising pclk edge where valid and
  // ready are both high; valid holds its payload stable until that edge.
  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, RESP = 2'd3} state_e;

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  state_e                  state_q;
  logic [CW-1:0]           cnt_q;
  logic [ADDR_WIDTH-1:0]   paddr_q;
  logic [2:0]              pprot_q;
  logic                    pwrite_q;
  logic [DATA_WIDTH-1:0]   pwdata_q;
  logic [DATA_WIDTH/8-1:0] pstrb_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic                    rsp_err_q;
  logic                    rsp_timeout_q;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      paddr_q       <= '0;
      pprot_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            paddr_q  <= cmd_addr;
            pprot_q  <= cmd_prot;
            pwrite_q <= cmd_write;
            // Reads carry no strobes and leave the old write data on the bus.
            if (cmd_write) begin
              pwdata_q <= cmd_wdata;
              pstrb_q  <= cmd_strb;
            end else begin
              pstrb_q  <= '0;
            end
            state_q <= SETUP;
          end
        end
        SETUP: begin
          cnt_q   <= '0;
          state_q <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            rsp_err_q     <= pslverr;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= pwrite_q ? '0 : prdata;
            state_q       <= RESP;
          end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_rdata_q   <= '0;
            state_q       <= RESP;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Bus controls decode straight from state so reset removes them at once.
  assign cmd_ready   = (state_q == IDLE);
  assign psel        = (state_q == SETUP) || (state_q == ACCESS);
  assign penable     = (state_q == ACCESS);
  assign rsp_valid   = (state_q == RESP);
  assign paddr       = paddr_q;
  assign pprot       = pprot_q;
  assign pwrite      = pwrite_q;
  assign pwdata      = pwdata_q;
  assign pstrb       = pstrb_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge (TIMEOUT=4): writes, waited reads,
// slave error, timeout, response backpressure and asynchronous reset.
module tb_apb_master_bridge;

  logic        pclk = 1'b0;
  logic        preset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [31:0] paddr, pwdata, prdata;
  logic [2:0]  pprot;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [3:0]  pstrb;
  logic [1:0]  state_dbg;

  int n_assert = 0;
  int n_fail   = 0;
  int acc;

  apb_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .pprot(pprot), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata), .pslverr(pslverr),
    .state_dbg(state_dbg)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issues one command at a negedge, checks the SETUP cycle, then plays the
  // slave: pready rises in ACCESS cycle ready_at (0 = never). Returns with the
  // response visible and the number of ACCESS cycles seen.
  task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] strb, input logic [31:0] exp_pwdata,
                         input logic [3:0] exp_pstrb, input int ready_at,
                         input logic err_v, input logic [31:0] rd_v, output int n_acc);
    bit done = 0;
    n_acc = 0;
    @(negedge pclk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
    cmd_strb = strb; cmd_prot = 3'b010; pready = 1'b0; pslverr = 1'b0;
    @(negedge pclk);
    cmd_valid = 1'b0; cmd_addr = 32'hFFFF_FFFF; cmd_wdata = 32'h0BAD_0BAD;
    chk("setup_psel", {psel, penable, cmd_ready}, 3'b100);
    chk("setup_paddr", paddr, addr);
    chk("setup_pwrite", pwrite, wr);
    chk("setup_pwdata", pwdata, exp_pwdata);
    chk("setup_pstrb", pstrb, exp_pstrb);
    chk("setup_pprot", pprot, 3'b010);
    @(negedge pclk);
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid) begin
        done = 1;
        break;
      end
      if (penable) begin
        n_acc++;
        chk("access_paddr", paddr, addr);
        chk("access_pstrb", pstrb, exp_pstrb);
        pready  = (n_acc == ready_at);
        pslverr = err_v;
        prdata  = rd_v;
      end
      @(negedge pclk);
    end
    pready = 1'b0; pslverr = 1'b0;
    chk("rsp_arrived", done, 1'b1);
    chk("rsp_psel_low", {psel, penable}, 2'b00);
  endtask

  initial begin
    preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_strb = '0; cmd_prot = '0; rsp_ready = 1'b1; pready = 1'b0; prdata = '0; pslverr = 1'b0;
    repeat (2) @(negedge pclk);
    chk("rst_ctrl", {cmd_ready, psel, penable, pwrite, rsp_valid}, 5'b10000);
    chk("rst_rsp", {rsp_err, rsp_timeout, rsp_rdata}, 34'h0);
    chk("rst_bus", {paddr, pwdata, pstrb, pprot}, 71'h0);
    chk("rst_state", state_dbg, 2'd0);
    preset = 1'b0;

    // Write, slave ready at once.
    do_xfer(1'b1, 32'h08, 32'hA5A5_0001, 4'hF, 32'hA5A5_0001, 4'hF, 1, 1'b0, 32'h0, acc);
    chk("wr_acc_cycles", acc, 1);
    chk("wr_rsp", {rsp_err, rsp_timeout, rsp_rdata}, 34'h0);
    @(negedge pclk);
    chk("wr_back_idle", {rsp_valid, cmd_ready}, 2'b01);

    // Read with 3 wait states; pwdata keeps the previous write data.
    do_xfer(1'b0, 32'h10, 32'h0, 4'hF, 32'hA5A5_0001, 4'h0, 4, 1'b0, 32'h1234_5678, acc);
    chk("rd_acc_cycles", acc, 4);
    chk("rd_rdata", rsp_rdata, 32'h1234_5678);
    chk("rd_err", {rsp_err, rsp_timeout}, 2'b00);

    // Slave error on a read still returns prdata.
    do_xfer(1'b0, 32'h40, 32'h0, 4'hF, 32'hA5A5_0001, 4'h0, 1, 1'b1, 32'hDEAD_BEEF, acc);
    chk("se_acc_cycles", acc, 1);
    chk("se_err", {rsp_err, rsp_timeout}, 2'b10);
    chk("se_rdata", rsp_rdata, 32'hDEAD_BEEF);

    // Timeout: pready never comes, ACCESS lasts exactly TIMEOUT cycles.
    do_xfer(1'b0, 32'h44, 32'h0, 4'h3, 32'hA5A5_0001, 4'h0, 0, 1'b1, 32'h7777_7777, acc);
    chk("to_acc_cycles", acc, 4);
    chk("to_err", {rsp_err, rsp_timeout}, 2'b11);
    chk("to_rdata", rsp_rdata, 32'h0);

    // pready on the last allowed cycle beats the timeout.
    do_xfer(1'b1, 32'h48, 32'h5555_AAAA, 4'h6, 32'h5555_AAAA, 4'h6, 4, 1'b0, 32'h7777_7777, acc);
    chk("to_edge_acc_cycles", acc, 4);
    chk("to_edge_err", {rsp_err, rsp_timeout}, 2'b00);
    chk("to_edge_rdata", rsp_rdata, 32'h0);

    // Backpressure with the next command already waiting.
    @(negedge pclk);
    rsp_ready = 1'b0;
    do_xfer(1'b0, 32'h20, 32'h0, 4'hF, 32'h5555_AAAA, 4'h0, 2, 1'b0, 32'hCAFE_0002, acc);
    chk("bp_acc_cycles", acc, 2);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h30; cmd_wdata = 32'h0000_0030; cmd_strb = 4'h1;
    for (int i = 0; i < 5; i++) begin
      @(negedge pclk);
      chk("bp_hold_ctrl", {cmd_ready, psel, rsp_valid}, 3'b001);
      chk("bp_hold_rsp", {rsp_err, rsp_timeout, rsp_rdata}, {2'b00, 32'hCAFE_0002});
    end
    rsp_ready = 1'b1;
    @(negedge pclk);
    chk("bp_idle", {cmd_ready, rsp_valid, psel}, 3'b100);
    @(negedge pclk);
    cmd_valid = 1'b0;
    chk("bp_next_setup", {psel, penable}, 2'b10);
    chk("bp_next_paddr", paddr, 32'h30);
    pready = 1'b1;
    @(negedge pclk);
    chk("bp_next_access", {psel, penable}, 2'b11);
    @(negedge pclk);
    pready = 1'b0;
    chk("bp_next_rsp", {rsp_valid, rsp_err}, 2'b10);
    @(negedge pclk);

    // Asynchronous reset in the middle of ACCESS.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h50;
    @(negedge pclk);
    cmd_valid = 1'b0;
    @(negedge pclk);
    chk("rstm_in_access", {psel, penable}, 2'b11);
    #2 preset = 1'b1;
    #1 chk("rstm_async_drop", {psel, penable, rsp_valid}, 3'b000);
    @(negedge pclk);
    preset = 1'b0;
    @(negedge pclk);
    chk("rstm_after", {cmd_ready, rsp_valid, psel}, 3'b100);
    chk("rstm_state", state_dbg, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
